// File: rtl/onewire_pkg.sv
// Shared constants for the multi-port 1-Wire master: register layout, slot timing in ticks,
// FSM encoding and helpers that pick the tick index ending each phase of a cycle.
package onewire_pkg;

  localparam int unsigned ADW = 32;

  // CTRL register bit positions
  localparam int unsigned CtrlDat  = 0;
  localparam int unsigned CtrlRst  = 1;
  localparam int unsigned CtrlOvd  = 2;
  localparam int unsigned CtrlBsy  = 3;
  localparam int unsigned CtrlDone = 4;
  localparam int unsigned CtrlIen  = 5;
  localparam int unsigned CtrlSel  = 8;

  // Cycle timing, in ticks since the start of the cycle
  localparam int unsigned T_SLOT = 8;
  localparam int unsigned T_WLOW = 7;
  localparam int unsigned T_SMP  = 2;
  localparam int unsigned T_RLOW = 64;
  localparam int unsigned T_PSMP = 73;
  localparam int unsigned T_RST  = 128;

  localparam int unsigned KW = 7;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLow  = 3'd1;
  localparam logic [2:0] StRel  = 3'd2;
  localparam logic [2:0] StSmp  = 3'd3;
  localparam logic [2:0] StWait = 3'd4;

  // Index of the last tick spent driving low; a read/write-1 slot only pulls for tick 0.
  function automatic logic [KW-1:0] low_end(input logic rst_cyc, input logic dat);
    if (rst_cyc) begin
      return KW'(T_RLOW - 1);
    end else if (dat) begin
      return KW'(0);
    end
    return KW'(T_WLOW - 1);
  endfunction

  function automatic logic [KW-1:0] smp_end(input logic rst_cyc);
    return rst_cyc ? KW'(T_PSMP - 1) : KW'(T_SMP - 1);
  endfunction

  function automatic logic [KW-1:0] cyc_end(input logic rst_cyc);
    return rst_cyc ? KW'(T_RST - 1) : KW'(T_SLOT - 1);
  endfunction

endpackage

// File: rtl/onewire_if.sv
// Avalon-MM slave bus bundle between the CPU fabric (master) and the 1-Wire controller (slave).
interface onewire_if;
  import onewire_pkg::*;

  logic           avalon_read;
  logic           avalon_write;
  logic           avalon_address;
  logic [ADW-1:0] avalon_writedata;
  logic [ADW-1:0] avalon_readdata;
  logic           avalon_waitrequest;
  logic           avalon_interrupt;

  modport master (
    output avalon_read, avalon_write, avalon_address, avalon_writedata,
    input  avalon_readdata, avalon_waitrequest, avalon_interrupt
  );

  modport slave (
    input  avalon_read, avalon_write, avalon_address, avalon_writedata,
    output avalon_readdata, avalon_waitrequest, avalon_interrupt
  );

endinterface

// File: rtl/onewire_tick.sv
// Slot-timing divider: free-runs while enabled, emits one-cycle tick on terminal count.
// Divide ratio follows ovd (DVO overdrive, DVN normal); clr restarts the count at zero.
module onewire_tick #(
  parameter int unsigned DVN = 180,
  parameter int unsigned DVO = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic ovd,
  output logic tick
);

  localparam int unsigned DMax = (DVN > DVO) ? DVN : DVO;
  localparam int unsigned CW   = (DMax > 2) ? $clog2(DMax) : 1;

  logic [CW-1:0] cnt_q, cnt_d, last;

  assign last = ovd ? CW'(DVO - 1) : CW'(DVN - 1);
  assign tick = en && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onewire_mp.sv
// Multi-port 1-Wire bus master behind an Avalon-MM slave: CTRL starts reset/presence or
// data slots on the selected open-drain line, SPU drives per-port strong pullups.
module onewire_mp
  import onewire_pkg::*;
#(
  parameter int unsigned OWN = 1,
  parameter int unsigned DVN = 180,
  parameter int unsigned DVO = 24
) (
  input  logic           clk,
  input  logic           rst,
  onewire_if.slave       bus,
  inout  wire  [OWN-1:0] onewire,
  output logic [OWN-1:0] onewire_p
);

  localparam int unsigned SW = (OWN > 1) ? $clog2(OWN) : 1;

  logic [2:0]     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic           tx_q, tx_d;
  logic           rcyc_q, rcyc_d;
  logic           ovd_q, ovd_d;
  logic           ien_q, ien_d;
  logic           dat_q, dat_d;
  logic           done_q, done_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [OWN-1:0] spu_q, spu_d;
  logic [OWN-1:0] sync1_q, sync2_q;
  logic [OWN-1:0] sel_oh, drive_low;
  logic [ADW-1:0] wd, rdata;
  logic           busy, tick, ctrl_wr, ctrl_rd, spu_wr, start, finish, smp_tick, line;
  logic           unused_wdata;

  assign wd           = bus.avalon_writedata;
  assign unused_wdata = ^wd;

  assign busy     = (state_q != StIdle);
  assign ctrl_wr  = bus.avalon_write && !bus.avalon_address;
  assign spu_wr   = bus.avalon_write && bus.avalon_address;
  assign ctrl_rd  = bus.avalon_read && !bus.avalon_address;
  assign start    = ctrl_wr && !busy;
  assign finish   = tick && (k_q == cyc_end(rcyc_q));
  assign smp_tick = tick && (k_q == smp_end(rcyc_q));

  onewire_tick #(
    .DVN (DVN),
    .DVO (DVO)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (start),
    .ovd  (ovd_q),
    .tick (tick)
  );

  // SEL values with no matching port leave sel_oh empty: nothing driven, sample reads idle-high.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < OWN; i++) begin
      sel_oh[i] = (sel_q == SW'(i));
    end
  end

  assign line      = (|sel_oh) ? |(sel_oh & sync2_q) : 1'b1;
  assign drive_low = (state_q == StLow) ? sel_oh : '0;
  assign onewire_p = spu_q & ~drive_low;

  for (genvar i = 0; i < OWN; i++) begin : g_line
    assign onewire[i] = drive_low[i] ? 1'b0 : 1'bz;
  end

  // Cycle end is checked in every busy state so short divide ratios cannot overrun it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLow;
      StLow:   if (tick && (k_q == low_end(rcyc_q, tx_q))) state_d = StRel;
      StRel:   if (smp_tick || (k_q > smp_end(rcyc_q))) state_d = StSmp;
      StSmp:   state_d = StWait;
      StWait:  state_d = StWait;
      default: state_d = StIdle;
    endcase
    if (finish) state_d = StIdle;
  end

  always_comb begin
    k_d    = k_q;
    tx_d   = tx_q;
    rcyc_d = rcyc_q;
    ovd_d  = ovd_q;
    sel_d  = sel_q;
    ien_d  = ien_q;
    dat_d  = dat_q;
    done_d = done_q;
    spu_d  = spu_q;
    if (start) begin
      tx_d   = wd[CtrlDat];
      rcyc_d = wd[CtrlRst];
      ovd_d  = wd[CtrlOvd];
      sel_d  = wd[CtrlSel +: SW];
      k_d    = '0;
    end else if (tick) begin
      k_d = k_q + KW'(1);
    end
    if (ctrl_wr)  ien_d = wd[CtrlIen];
    if (spu_wr)   spu_d = wd[OWN-1:0];
    if (smp_tick) dat_d = line;
    // Completion beats a coincident CTRL read so DONE is never lost.
    if (finish) begin
      done_d = 1'b1;
    end else if (start || ctrl_rd) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      tx_q    <= 1'b0;
      rcyc_q  <= 1'b0;
      ovd_q   <= 1'b0;
      sel_q   <= '0;
      ien_q   <= 1'b0;
      dat_q   <= 1'b0;
      done_q  <= 1'b0;
      spu_q   <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      rcyc_q  <= rcyc_d;
      ovd_q   <= ovd_d;
      sel_q   <= sel_d;
      ien_q   <= ien_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      spu_q   <= spu_d;
      sync1_q <= onewire;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (!bus.avalon_address) begin
      rdata[CtrlDat]       = dat_q;
      rdata[CtrlRst]       = rcyc_q;
      rdata[CtrlOvd]       = ovd_q;
      rdata[CtrlBsy]       = busy;
      rdata[CtrlDone]      = done_q;
      rdata[CtrlIen]       = ien_q;
      rdata[CtrlSel +: SW] = sel_q;
    end else begin
      rdata[OWN-1:0] = spu_q;
    end
  end

  assign bus.avalon_readdata    = rdata;
  assign bus.avalon_waitrequest = 1'b0;
  assign bus.avalon_interrupt   = ien_q & done_q;

endmodule

// File: tb/tb_onewire_mp.sv
// Bench for onewire_mp (OWN=4, 24 MHz timing): table of bus cycles with a timed slave model
// and scoreboard, plus hand sequences for IRQ, mid-cycle writes, DONE collision and reset.
module tb_onewire_mp;

  localparam int OWN = 4;
  localparam int DVN = 180;
  localparam int DVO = 24;

  typedef struct {
    logic [31:0] ctrl;
    logic [3:0]  spu;
    int          port;
    int          slv_from;
    int          slv_to;
    int          div;
    int          low_t;
    int          done_t;
    logic        dat;
  } vec_t;

  typedef struct {
    int   low_cyc;
    int   done_cyc;
    logic dat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [OWN-1:0] slv_low;
  logic [OWN-1:0] ow_p;
  wire  [OWN-1:0] ow;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  onewire_if bus ();

  for (genvar i = 0; i < OWN; i++) begin : g_bus
    pullup pu (ow[i]);
    assign ow[i] = slv_low[i] ? 1'b0 : 1'bz;
  end

  onewire_mp #(
    .OWN (OWN),
    .DVN (DVN),
    .DVO (DVO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .onewire   (ow),
    .onewire_p (ow_p)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    bus.avalon_address   = a;
    bus.avalon_writedata = d;
    bus.avalon_write     = 1'b1;
    step();
    bus.avalon_write   = 1'b0;
    bus.avalon_address = 1'b0;
  endtask

  task automatic ctrl_read();
    bus.avalon_address = 1'b0;
    bus.avalon_read    = 1'b1;
    step();
    bus.avalon_read = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   n, low, other, pbad, limit;
    logic done, mlow, exp_p;
    exp_t e;
    bus_write(1'b1, {28'h0, v.spu});
    bus_write(1'b0, v.ctrl);
    sb.push_back('{low_cyc: v.low_t * v.div, done_cyc: v.done_t * v.div, dat: v.dat});
    n = 0; low = 0; other = 0; pbad = 0; done = 1'b0;
    limit = v.done_t * v.div + 50;
    while (!done && n <= limit) begin
      slv_low = '0;
      if (n >= v.slv_from * v.div && n < v.slv_to * v.div) slv_low[v.port] = 1'b1;
      #1;
      mlow = (ow[v.port] == 1'b0) && !slv_low[v.port];
      if (mlow) low++;
      for (int j = 0; j < OWN; j++) begin
        if (j != v.port && ow[j] == 1'b0) other++;
        exp_p = v.spu[j] && !(j == v.port && mlow);
        if (ow_p[j] != exp_p) pbad++;
      end
      if (bus.avalon_readdata[4]) done = 1'b1;
      else begin
        step();
        n++;
      end
    end
    slv_low = '0;
    e = sb.pop_front();
    chk("done_cycle", n, e.done_cyc);
    chk("low_cycles", low, e.low_cyc);
    chk("dat", {31'h0, bus.avalon_readdata[0]}, {31'h0, e.dat});
    chk("bsy_done", {30'h0, bus.avalon_readdata[4:3]}, 32'h2);
    chk("other_lines_low", other, 0);
    chk("spu_rule", pbad, 0);
    ctrl_read();
    #1;
    chk("done_cleared", {31'h0, bus.avalon_readdata[4]}, 32'h0);
  endtask

  initial begin
    int   cyc, other;
    logic irq_prev, done;

    vecs[0] = '{ctrl: 32'h102, spu: 4'h0, port: 1, slv_from: 66, slv_to: 80, div: DVN,
                low_t: 64, done_t: 128, dat: 1'b0};
    vecs[1] = '{ctrl: 32'h001, spu: 4'h0, port: 0, slv_from: 1, slv_to: 3, div: DVN,
                low_t: 1, done_t: 8, dat: 1'b0};
    vecs[2] = '{ctrl: 32'h001, spu: 4'h0, port: 0, slv_from: 0, slv_to: 0, div: DVN,
                low_t: 1, done_t: 8, dat: 1'b1};
    vecs[3] = '{ctrl: 32'h004, spu: 4'h0, port: 0, slv_from: 0, slv_to: 0, div: DVO,
                low_t: 7, done_t: 8, dat: 1'b0};
    vecs[4] = '{ctrl: 32'h301, spu: 4'h8, port: 3, slv_from: 0, slv_to: 0, div: DVN,
                low_t: 1, done_t: 8, dat: 1'b1};
    vecs[5] = '{ctrl: 32'h300, spu: 4'h8, port: 3, slv_from: 0, slv_to: 0, div: DVN,
                low_t: 7, done_t: 8, dat: 1'b0};
    vecs[6] = '{ctrl: 32'h205, spu: 4'h5, port: 2, slv_from: 1, slv_to: 2, div: DVO,
                low_t: 1, done_t: 8, dat: 1'b0};
    vecs[7] = '{ctrl: 32'h106, spu: 4'h0, port: 1, slv_from: 0, slv_to: 0, div: DVO,
                low_t: 64, done_t: 128, dat: 1'b1};

    rst = 1'b1;
    slv_low = '0;
    bus.avalon_read = 1'b0;
    bus.avalon_write = 1'b0;
    bus.avalon_address = 1'b0;
    bus.avalon_writedata = '0;
    step(); step();
    rst = 1'b0;
    step();

    chk("reset_ctrl", bus.avalon_readdata, 32'h0);
    chk("reset_irq", {31'h0, bus.avalon_interrupt}, 32'h0);
    chk("reset_wait", {31'h0, bus.avalon_waitrequest}, 32'h0);
    chk("reset_lines", {28'h0, ow}, 32'hF);
    chk("reset_pullup", {28'h0, ow_p}, 32'h0);
    bus.avalon_address = 1'b1;
    #1;
    chk("reset_spu", bus.avalon_readdata, 32'h0);
    bus.avalon_address = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // IEN cycle with mid-cycle CTRL writes that may only touch IEN
    bus_write(1'b1, 32'h0);
    bus_write(1'b0, 32'h021);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cyc++;
    end
    bus_write(1'b0, 32'h106);
    cyc++;
    chk("busy_write_ien0", bus.avalon_readdata & 32'h3FE, 32'h008);
    bus_write(1'b0, 32'h326);
    cyc++;
    chk("busy_write_ien1", bus.avalon_readdata & 32'h3FE, 32'h028);
    other = 0; done = 1'b0; irq_prev = 1'b0;
    while (!done && cyc <= 8 * DVN + 50) begin
      if (ow[3:1] != 3'b111) other++;
      if (bus.avalon_readdata[4]) done = 1'b1;
      else begin
        irq_prev = bus.avalon_interrupt;
        step();
        cyc++;
      end
    end
    chk("no_restart_done_cycle", cyc, 8 * DVN);
    chk("ignored_sel_lines", other, 0);
    chk("irq_low_before_done", {31'h0, irq_prev}, 32'h0);
    chk("irq_with_done", {31'h0, bus.avalon_interrupt}, 32'h1);
    ctrl_read();
    chk("irq_cleared_by_read", {31'h0, bus.avalon_interrupt}, 32'h0);

    // CTRL read lands on the completing edge: old value returned, DONE set anyway
    bus_write(1'b0, 32'h005);
    for (int i = 0; i < 8 * DVO - 1; i++) step();
    bus.avalon_read = 1'b1;
    #1;
    chk("collide_read_old", {31'h0, bus.avalon_readdata[4]}, 32'h0);
    step();
    bus.avalon_read = 1'b0;
    chk("collide_done_wins", {30'h0, bus.avalon_readdata[4:3]}, 32'h2);
    ctrl_read();

    // Reset asserted during tick 30 of a reset/presence cycle
    bus_write(1'b1, 32'h2);
    bus_write(1'b0, 32'h102);
    for (int i = 0; i < 30 * DVN + 10; i++) step();
    chk("mid_reset_low", {31'h0, ow[1]}, 32'h0);
    chk("mid_reset_pullup_off", {28'h0, ow_p}, 32'h0);
    rst = 1'b1;
    step();
    chk("rst_lines_z", {28'h0, ow}, 32'hF);
    chk("rst_readdata", bus.avalon_readdata, 32'h0);
    chk("rst_pullup", {28'h0, ow_p}, 32'h0);
    rst = 1'b0;
    step();
    bus.avalon_address = 1'b1;
    #1;
    chk("rst_spu", bus.avalon_readdata, 32'h0);
    bus.avalon_address = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
